// File: rtl/miriscv_rvfi_pkg.sv
// Shared types for the miriscv RVFI trace path: the retirement record and the
// buffered entry that pairs a record with its retirement order stamp.
package miriscv_rvfi_pkg;

  localparam int RVFI_XLEN    = 32;
  localparam int RVFI_ORDER_W = 64;

  typedef struct packed {
    logic [31:0]          insn;
    logic                 trap;
    logic [RVFI_XLEN-1:0] pc_rdata;
    logic [RVFI_XLEN-1:0] pc_wdata;
    logic [4:0]           rd_addr;
    logic [RVFI_XLEN-1:0] rd_wdata;
    logic [RVFI_XLEN-1:0] mem_addr;
    logic [3:0]           mem_rmask;
    logic [3:0]           mem_wmask;
    logic [RVFI_XLEN-1:0] mem_rdata;
    logic [RVFI_XLEN-1:0] mem_wdata;
  } rvfi_pkt_t;

  typedef struct packed {
    rvfi_pkt_t               pkt;
    logic [RVFI_ORDER_W-1:0] order;
  } rvfi_entry_t;

endpackage

// File: rtl/miriscv_rvfi_fifo.sv
// Generic synchronous FIFO with a registered head: a push into an empty FIFO is
// visible one edge later, and the head only changes on a pop or on the first push.
module miriscv_rvfi_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  T                         wdata_i,
  input  logic                     pop_i,
  output T                         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  T               mem_q [DEPTH];
  T               rdata_q, rdata_d;
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic           push_acc, pop_acc, head_upd;

  assign empty_o  = (wr_q == rd_q);
  assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_acc  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_acc = push_i && (!full_o || pop_acc);
  assign wr_d     = wr_q + PW'(push_acc);
  assign rd_d     = rd_q + PW'(pop_acc);
  assign count_next_o = wr_d - rd_d;
  assign head_upd = pop_acc || (push_acc && empty_o);

  // The new head is the incoming word when it lands exactly at the next read slot.
  always_comb begin
    rdata_d = mem_q[rd_d[AW-1:0]];
    if (push_acc && (rd_d[AW-1:0] == wr_q[AW-1:0])) rdata_d = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (head_upd) rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/miriscv_rvfi_trace_buffer.sv
// Buffers retired-instruction records between the core and the RVFI consumer,
// stamping retirement order, requesting core stalls early and counting drops.
module miriscv_rvfi_trace_buffer
  import miriscv_rvfi_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 2,
  parameter int ORDER_W      = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               retire_valid_i,
  input  rvfi_pkt_t          retire_pkt_i,
  output logic               core_stall_o,
  output logic               rvfi_valid_o,
  input  logic               rvfi_ready_i,
  output rvfi_pkt_t          rvfi_pkt_o,
  output logic [ORDER_W-1:0] rvfi_order_o,
  output logic               overflow_o,
  output logic [15:0]        drop_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  rvfi_entry_t        wentry, rentry;
  logic               fifo_full, fifo_empty, pop, drop;
  logic [CW-1:0]      count_next;
  logic [ORDER_W-1:0] order_q;
  logic               stall_q, ovf_q;
  logic [15:0]        drop_q;

  assign pop          = !fifo_empty && rvfi_ready_i;
  assign drop         = retire_valid_i && fifo_full && !pop;
  assign wentry.pkt   = retire_pkt_i;
  assign wentry.order = RVFI_ORDER_W'(order_q);

  miriscv_rvfi_fifo #(
    .T     (rvfi_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (retire_valid_i),
    .wdata_i      (wentry),
    .pop_i        (pop),
    .rdata_o      (rentry),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_next_o (count_next)
  );

  // Order advances on every retirement, dropped or not, so losses show as gaps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      order_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (retire_valid_i) order_q <= order_q + 1'b1;
      stall_q <= (count_next >= CW'(DEPTH - STALL_MARGIN));
      if (drop) ovf_q <= 1'b1;
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign core_stall_o = stall_q;
  assign rvfi_valid_o = !fifo_empty;
  assign rvfi_pkt_o   = rentry.pkt;
  assign rvfi_order_o = rentry.order[ORDER_W-1:0];
  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_miriscv_rvfi_trace_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_miriscv_rvfi_trace_buffer;
  import miriscv_rvfi_pkg::*;

  localparam int DEPTH = 8, MARGIN = 2, ORDER_W = 64, CW = 300;

  typedef struct {
    rvfi_pkt_t   pkt;
    logic [63:0] order;
  } rec_t;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic               retire_valid_i = 1'b0;
  rvfi_pkt_t          retire_pkt_i = '0;
  logic               core_stall_o;
  logic               rvfi_valid_o;
  logic               rvfi_ready_i = 1'b0;
  rvfi_pkt_t          rvfi_pkt_o;
  logic [ORDER_W-1:0] rvfi_order_o;
  logic               overflow_o;
  logic [15:0]        drop_cnt_o;

  miriscv_rvfi_trace_buffer #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN), .ORDER_W(ORDER_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .retire_valid_i (retire_valid_i),
    .retire_pkt_i   (retire_pkt_i),
    .core_stall_o   (core_stall_o),
    .rvfi_valid_o   (rvfi_valid_o),
    .rvfi_ready_i   (rvfi_ready_i),
    .rvfi_pkt_o     (rvfi_pkt_o),
    .rvfi_order_o   (rvfi_order_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  rec_t        mq[$];
  logic [63:0] m_order;
  int          m_drops;
  bit          m_ovf, m_stall;
  int          n_vec = 0, n_miss = 0;

  bit          gap_on = 0, have_prev = 0;
  logic [63:0] prev_ord;
  longint      gap_sum;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rvfi_pkt_t rand_pkt();
    rvfi_pkt_t p;
    p.insn      = $urandom();
    p.trap      = 1'($urandom());
    p.pc_rdata  = $urandom();
    p.pc_wdata  = $urandom();
    p.rd_addr   = 5'($urandom());
    p.rd_wdata  = $urandom();
    p.mem_addr  = $urandom();
    p.mem_rmask = 4'($urandom());
    p.mem_wmask = 4'($urandom());
    p.mem_rdata = $urandom();
    p.mem_wdata = $urandom();
    return p;
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare just after.
  task automatic step(input bit rst, input bit rv, input rvfi_pkt_t pkt, input bit rdy);
    bit popd;
    rst_i = rst; retire_valid_i = rv; retire_pkt_i = pkt; rvfi_ready_i = rdy;
    #1;
    if (gap_on && !rst && rvfi_valid_o && rdy) begin
      if (have_prev) begin
        check_eq("order_incr", CW'(rvfi_order_o > prev_ord), CW'(1));
        gap_sum += longint'(rvfi_order_o - prev_ord - 64'd1);
      end else begin
        gap_sum += longint'(rvfi_order_o);
      end
      prev_ord  = rvfi_order_o;
      have_prev = 1;
    end
    @(posedge clk_i);
    if (rst) begin
      mq.delete();
      m_order = '0; m_drops = 0; m_ovf = 0;
    end else begin
      popd = (mq.size() != 0) && rdy;
      if (popd) void'(mq.pop_front());
      if (rv) begin
        if (mq.size() < DEPTH) mq.push_back('{pkt, m_order});
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
        m_order = m_order + 64'd1;
      end
    end
    m_stall = !rst && (mq.size() >= DEPTH - MARGIN);
    #1;
    check_eq("valid", CW'(rvfi_valid_o), CW'(mq.size() != 0));
    check_eq("stall", CW'(core_stall_o), CW'(m_stall));
    check_eq("overflow", CW'(overflow_o), CW'(m_ovf));
    check_eq("drop_cnt", CW'(drop_cnt_o), CW'(m_drops));
    if (mq.size() != 0) begin
      check_eq("head_pkt", CW'(rvfi_pkt_o), CW'(mq[0].pkt));
      check_eq("head_order", CW'(rvfi_order_o), CW'(mq[0].order));
    end
  endtask

  initial begin
    rvfi_pkt_t p;
    int pv, pr;
    m_order = '0; m_drops = 0; m_ovf = 0; m_stall = 0;

    step(1, 0, '0, 0);
    step(1, 1, rand_pkt(), 1);
    check_eq("rst_pkt", CW'(rvfi_pkt_o), CW'(0));
    check_eq("rst_order", CW'(rvfi_order_o), CW'(0));

    // Single retire with minimum latency
    p = '0; p.insn = 32'h00500093; p.pc_wdata = 32'h4;
    step(0, 1, p, 1);
    check_eq("t1_insn", CW'(rvfi_pkt_o.insn), CW'(32'h00500093));
    check_eq("t1_order", CW'(rvfi_order_o), CW'(0));
    step(0, 0, '0, 1);
    check_eq("t1_empty", CW'(rvfi_valid_o), CW'(0));

    // Stall threshold then drain
    step(1, 0, '0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, rand_pkt(), 0);
    check_eq("t2_stall", CW'(core_stall_o), CW'(1));
    for (int i = 0; i < 7; i++) step(0, 0, '0, 1);
    check_eq("t2_drops", CW'(drop_cnt_o), CW'(0));

    // Overflow with two drops
    step(1, 0, '0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, rand_pkt(), 0);
    check_eq("t3_drops", CW'(drop_cnt_o), CW'(2));
    check_eq("t3_ovf", CW'(overflow_o), CW'(1));
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
    step(0, 1, rand_pkt(), 1);
    check_eq("t3_next_order", CW'(rvfi_order_o), CW'(10));

    // Full with simultaneous push and pop
    step(1, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, rand_pkt(), 0);
    step(0, 1, rand_pkt(), 1);
    check_eq("t4_drops", CW'(drop_cnt_o), CW'(0));
    for (int i = 0; i < 9; i++) step(0, 0, '0, 1);

    // Reset mid-stream
    step(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, rand_pkt(), 0);
    step(1, 1, rand_pkt(), 1);
    check_eq("t5_valid", CW'(rvfi_valid_o), CW'(0));
    check_eq("t5_ovf", CW'(overflow_o), CW'(0));
    step(0, 1, rand_pkt(), 0);
    check_eq("t5_order", CW'(rvfi_order_o), CW'(0));

    // Random traffic with order-gap accounting
    step(1, 0, '0, 0);
    gap_on = 1; have_prev = 0; gap_sum = 0;
    for (int i = 0; i < 10000; i++) begin
      case ((i / 256) % 4)
        0: begin pv = 80; pr = 5;  end
        1: begin pv = 50; pr = 50; end
        2: begin pv = 70; pr = 95; end
        default: begin pv = 90; pr = 30; end
      endcase
      step(0, ($urandom_range(0, 99) < pv), rand_pkt(), ($urandom_range(0, 99) < pr));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, '0, 1);
    step(0, 1, rand_pkt(), 1);
    step(0, 0, '0, 1);
    gap_on = 0;
    check_eq("gap_vs_drops", CW'(gap_sum), CW'(drop_cnt_o));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
